uart_autobaud_ctrl: RTL and testbench
=====================================

// Module: uart_autobaud_ctrl
// PURPOSE
//  Configures the UART 16x baud generator automatically. Armed by firmware, it watches rx
//  for a 0x55 sync character and times 8 bit periods in clk cycles. It then derives
//  baud_val[12:0] and baud_val_fraction[2:0] and drives them to the baud generator.
//  Sits between the APB register block and the clock generator / rx path.
// PARAMETERS
//  CNT_W            21    width of total-period counter T; T saturating at all-ones = timeout
//  IDLE_CLKS        256   consecutive high rx cycles required before a start edge is accepted
//  DEFAULT_BAUD_VAL 13'd0 baud_val value after reset
//  AUTO_RETRY       1     1: after error re-arm (WAIT_IDLE); 0: go to IDLE
// PORTS
//  clk                input  1   system clock
//  reset              input  1   synchronous, active-high reset
//  rx                 input  1   asynchronous serial line (idle high)
//  start              input  1   one-cycle arm pulse; ignored unless state is IDLE
//  abort              input  1   one-cycle cancel; state to IDLE next cycle, outputs retained
//  baud_val           output 13  integer divisor to baud generator
//  baud_val_fraction  output 3   eighths fraction to baud generator
//  baud_update        output 1   one-cycle pulse when new baud_val/fraction take effect
//  locked             output 1   a valid measurement has completed since reset
//  busy               output 1   high in any state other than IDLE
//  err                output 1   one-cycle pulse on a failed measurement
// BEHAVIOUR
//  - Reset: state IDLE, baud_val=DEFAULT_BAUD_VAL, fraction=0, locked=0, busy=0.
//    Reset also sets baud_update=0 and err=0, and clears all counters.
//  - rx passes 2 sync flops, then a delay flop gives fall/rise. Edge seen 3 clk after pin.
//  - FSM: IDLE -start-> WAIT_IDLE. WAIT_IDLE counts synced-high cycles; low clears count.
//    WAIT_IDLE goes to WAIT_START when count reaches IDLE_CLKS.
//    WAIT_START -fall-> MEASURE, with T=0, interval counter I=0 and edge index e=0.
//    MEASURE: T and I increment each cycle. On fall, interval I is stored, I=0, e++.
//    MEASURE goes to CHECK_STOP when e reaches 4 (5th falling edge, T = 8 bit times).
//    CHECK_STOP counts until rise, then -> EVAL. EVAL takes 1 cycle -> DONE or ERROR.
//    DONE: 1 cycle, pulses baud_update and sets locked -> IDLE.
//    ERROR: 1 cycle, pulses err -> WAIT_IDLE if AUTO_RETRY else IDLE.
//  - Fall in the same cycle as T saturation counts as saturation (error).
//  - Validation in EVAL; any failure gives ERROR:
//    (a) T >= 128; (b) T did not saturate in MEASURE or CHECK_STOP;
//    (c) each of intervals I1..I3 is within I0 +/- (I0>>3), where I0 is the first interval;
//    (d) the stop-edge interval S (last fall to rise) is within (T>>3) +/- (T>>6).
//  - Result: baud_val = T[CNT_W-1:7] - 1, truncated to 13 bits; fraction = T[6:4].
//    Divisor per 16x tick = T/128, so baud_val + fraction/8 + 1 = T/128 (truncated).
//  - baud_val and fraction change only in DONE, in the same cycle as baud_update.
//    On error or abort they keep their previous values.
//  - Abort has priority over every transition, except that reset takes precedence.
//    Abort in DONE or ERROR suppresses that cycle's pulse.
//  - Reset mid-measurement returns all outputs to reset values next cycle.
//  - Arithmetic: comparisons unsigned, widened 1 bit to avoid overflow.
//    T saturates at 2^CNT_W-1 and never wraps.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE, WAIT_IDLE, WAIT_START, MEASURE, CHECK_STOP,
//    EVAL, DONE, ERROR), CNT_W default, sync char 8'h55, tolerance shifts (3, 6).
//  - One sub-module, uart_rx_sync_edge: 2-FF synchroniser plus delay flop.
//    Its outputs are rx_s, rx_fall and rx_rise.
//  - Top: FSM, T/I/idle counters, interval registers, EVAL comparators, output registers.
// TESTING
//  1. 115200 baud at 50 MHz: 0x55 with 434-clk bits, T=3472.
//     Expect baud_val=26, frac=1, baud_update 1 pulse, locked=1.
//  2. 9600 baud at 50 MHz: 5208-clk bits, T=41664. Expect baud_val=324, frac=4.
//  3. Char 0x41 at 434-clk bits: I1 = 3*I0, so expect err pulse.
//     baud_val unchanged, state WAIT_IDLE (AUTO_RETRY=1).
//  4. 0x55 with 10-clk bits (T=80): expect err. Then a valid 0x55 gives correct baud_update.
//  5. rx held low after start edge: T saturates, expect err, no baud_update.
//     With AUTO_RETRY=0, expect busy=0 afterwards.
//  6. Abort in MEASURE: busy=0 next cycle, no pulses, outputs kept.
//     Reset in CHECK_STOP: all outputs at reset values next cycle, locked=0.

Source files
------------

// File: rtl/uart_autobaud_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : uart_autobaud_ctrl_pkg
// Brief   : Shared state encoding and constants for the UART auto-baud block.
// Revision: 1.0
// ----------------------------------------------------------------------------
package uart_autobaud_ctrl_pkg;

  localparam int unsigned c_cnt_w_default = 21;
  localparam logic [7:0]  c_sync_char     = 8'h55;
  localparam int unsigned c_tol_i_shift   = 3;
  localparam int unsigned c_tol_s_shift   = 6;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_IDLE  = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_MEASURE    = 3'd3,
    ST_CHECK_STOP = 3'd4,
    ST_EVAL       = 3'd5,
    ST_DONE       = 3'd6,
    ST_ERROR      = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync_edge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : uart_rx_sync_edge
// Brief   : Two-flop synchroniser for rx plus a delay flop for edge detection.
// Revision: 1.0
// ----------------------------------------------------------------------------
module uart_rx_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_rx_fall,
  output logic o_rx_rise
);

  logic r_s1;
  logic r_s2;
  logic r_dly;

  // Flops reset to the idle-high line level so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1  <= 1'b1;
      r_s2  <= 1'b1;
      r_dly <= 1'b1;
    end else begin
      r_s1  <= i_rx;
      r_s2  <= r_s1;
      r_dly <= r_s2;
    end
  end

  assign o_rx_s    = r_s2;
  assign o_rx_fall = r_dly & ~r_s2;
  assign o_rx_rise = ~r_dly & r_s2;

endmodule
`default_nettype wire

// File: rtl/uart_autobaud_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : uart_autobaud_ctrl
// Brief   : Times a 0x55 sync character on rx and programs the 16x baud divisor.
// Revision: 1.0
// ----------------------------------------------------------------------------
module uart_autobaud_ctrl
  import uart_autobaud_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W            = c_cnt_w_default,
  parameter int unsigned IDLE_CLKS        = 256,
  parameter logic [12:0] DEFAULT_BAUD_VAL = 13'd0,
  parameter bit          AUTO_RETRY       = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_rx,
  input  logic        i_start,
  input  logic        i_abort,
  output logic [12:0] o_baud_val,
  output logic [2:0]  o_baud_val_fraction,
  output logic        o_baud_update,
  output logic        o_locked,
  output logic        o_busy,
  output logic        o_err
);

  localparam int unsigned       c_idle_w    = $clog2(IDLE_CLKS + 1);
  localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(IDLE_CLKS - 1);
  localparam logic [c_idle_w-1:0] c_idle_one  = c_idle_w'(1);
  localparam logic [CNT_W-1:0]  c_t_max     = '1;
  localparam logic [CNT_W-1:0]  c_one       = CNT_W'(1);
  localparam logic [CNT_W:0]    c_t_min     = (CNT_W + 1)'(128);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_done_pulse;
  logic                w_err_pulse;

  logic                w_rx_s;
  logic                w_rx_fall;
  logic                w_rx_rise;

  logic [c_idle_w-1:0] r_idle_cnt;
  logic [CNT_W-1:0]    r_t;
  logic [CNT_W-1:0]    r_i;
  logic [1:0]          r_e;
  logic [CNT_W-1:0]    r_ivl [4];
  logic [CNT_W-1:0]    r_s;
  logic                r_sat;

  logic [CNT_W-1:0]    w_t_inc;
  logic [CNT_W-1:0]    w_i_inc;
  logic [CNT_W:0]      w_i0;
  logic [CNT_W:0]      w_i_lo;
  logic [CNT_W:0]      w_i_hi;
  logic [CNT_W:0]      w_s_ctr;
  logic [CNT_W:0]      w_s_tol;
  logic                w_ivl_ok;
  logic                w_stop_ok;
  logic                w_eval_ok;
  logic [CNT_W-1:0]    w_t_div;

  logic [12:0]         r_baud_val;
  logic [2:0]          r_baud_frac;
  logic                r_baud_update;
  logic                r_locked;
  logic                r_err;

  uart_rx_sync_edge u_sync (
    .clk       (clk),
    .reset     (reset),
    .i_rx      (i_rx),
    .o_rx_s    (w_rx_s),
    .o_rx_fall (w_rx_fall),
    .o_rx_rise (w_rx_rise)
  );

  // Both counters saturate instead of wrapping; hitting all-ones is the timeout.
  assign w_t_inc = (r_t == c_t_max) ? c_t_max : r_t + c_one;
  assign w_i_inc = (r_i == c_t_max) ? c_t_max : r_i + c_one;

  assign w_i0    = {1'b0, r_ivl[0]};
  assign w_i_lo  = w_i0 - (w_i0 >> c_tol_i_shift);
  assign w_i_hi  = w_i0 + (w_i0 >> c_tol_i_shift);
  assign w_s_ctr = {1'b0, r_t} >> 3;
  assign w_s_tol = {1'b0, r_t} >> c_tol_s_shift;

  always_comb begin
    w_ivl_ok = 1'b1;
    for (int k = 1; k < 4; k++) begin
      if (({1'b0, r_ivl[k]} < w_i_lo) || ({1'b0, r_ivl[k]} > w_i_hi)) begin
        w_ivl_ok = 1'b0;
      end
    end
  end

  assign w_stop_ok = ({1'b0, r_s} >= (w_s_ctr - w_s_tol)) &&
                     ({1'b0, r_s} <= (w_s_ctr + w_s_tol));
  assign w_eval_ok = ({1'b0, r_t} >= c_t_min) && !r_sat && w_ivl_ok && w_stop_ok;
  assign w_t_div   = (r_t >> 7) - c_one;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_done_pulse = 1'b0;
    w_err_pulse  = 1'b0;
    case (r_state)
      ST_IDLE:       if (i_start) w_state_nxt = ST_WAIT_IDLE;
      ST_WAIT_IDLE:  if (w_rx_s && (r_idle_cnt == c_idle_last)) w_state_nxt = ST_WAIT_START;
      ST_WAIT_START: if (w_rx_fall) w_state_nxt = ST_MEASURE;
      ST_MEASURE: begin
        if (w_t_inc == c_t_max) begin
          w_state_nxt = ST_EVAL;
        end else if (w_rx_fall && (r_e == 2'd3)) begin
          w_state_nxt = ST_CHECK_STOP;
        end
      end
      ST_CHECK_STOP: if (w_rx_rise || (w_i_inc == c_t_max)) w_state_nxt = ST_EVAL;
      ST_EVAL:       w_state_nxt = w_eval_ok ? ST_DONE : ST_ERROR;
      ST_DONE: begin
        w_done_pulse = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      ST_ERROR: begin
        w_err_pulse = 1'b1;
        w_state_nxt = AUTO_RETRY ? ST_WAIT_IDLE : ST_IDLE;
      end
      default:       w_state_nxt = ST_IDLE;
    endcase
    if (i_abort) begin
      w_state_nxt  = ST_IDLE;
      w_done_pulse = 1'b0;
      w_err_pulse  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idle_cnt <= '0;
      r_t        <= '0;
      r_i        <= '0;
      r_e        <= '0;
      r_s        <= '0;
      r_sat      <= 1'b0;
      for (int k = 0; k < 4; k++) r_ivl[k] <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ERROR: r_idle_cnt <= '0;
        ST_WAIT_IDLE:      r_idle_cnt <= w_rx_s ? r_idle_cnt + c_idle_one : '0;
        ST_WAIT_START: begin
          r_t   <= '0;
          r_i   <= '0;
          r_e   <= '0;
          r_sat <= 1'b0;
        end
        ST_MEASURE: begin
          r_t <= w_t_inc;
          if (w_t_inc == c_t_max) r_sat <= 1'b1;
          // Stored interval includes the edge cycle so four intervals sum to T.
          if (w_rx_fall) begin
            r_ivl[r_e] <= w_i_inc;
            r_i        <= '0;
            r_e        <= r_e + 2'd1;
          end else begin
            r_i <= w_i_inc;
          end
        end
        ST_CHECK_STOP: begin
          r_i <= w_i_inc;
          if (w_i_inc == c_t_max) r_sat <= 1'b1;
          if (w_rx_rise) r_s <= w_i_inc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_baud_val    <= DEFAULT_BAUD_VAL;
      r_baud_frac   <= '0;
      r_baud_update <= 1'b0;
      r_locked      <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_baud_update <= w_done_pulse;
      r_err         <= w_err_pulse;
      if (w_done_pulse) begin
        r_baud_val  <= 13'(w_t_div);
        r_baud_frac <= r_t[6:4];
        r_locked    <= 1'b1;
      end
    end
  end

  assign o_baud_val          = r_baud_val;
  assign o_baud_val_fraction = r_baud_frac;
  assign o_baud_update       = r_baud_update;
  assign o_locked            = r_locked;
  assign o_err               = r_err;
  assign o_busy              = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_autobaud_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_uart_autobaud_ctrl
// Brief   : Scoreboard bench for the auto-baud controller (two configurations).
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_uart_autobaud_ctrl;
  import uart_autobaud_ctrl_pkg::*;

  localparam int unsigned c_idle = 256;

  typedef struct packed {
    logic        is_err;
    logic [12:0] baud;
    logic [2:0]  frac;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic        a_rx = 1'b1, a_start = 1'b0, a_abort = 1'b0;
  logic [12:0] a_baud;
  logic [2:0]  a_frac;
  logic        a_upd, a_locked, a_busy, a_err;

  logic        b_rx = 1'b1, b_start = 1'b0, b_abort = 1'b0;
  logic [12:0] b_baud;
  logic [2:0]  b_frac;
  logic        b_upd, b_locked, b_busy, b_err;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  logic [12:0] m_baud = 13'd0;
  logic [2:0]  m_frac = 3'd0;

  always #5 clk = ~clk;

  uart_autobaud_ctrl #(
    .CNT_W(16), .IDLE_CLKS(c_idle), .DEFAULT_BAUD_VAL(13'd0), .AUTO_RETRY(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset), .i_rx(a_rx), .i_start(a_start), .i_abort(a_abort),
    .o_baud_val(a_baud), .o_baud_val_fraction(a_frac), .o_baud_update(a_upd),
    .o_locked(a_locked), .o_busy(a_busy), .o_err(a_err)
  );

  uart_autobaud_ctrl #(
    .CNT_W(13), .IDLE_CLKS(c_idle), .DEFAULT_BAUD_VAL(13'd77), .AUTO_RETRY(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .i_rx(b_rx), .i_start(b_start), .i_abort(b_abort),
    .o_baud_val(b_baud), .o_baud_val_fraction(b_frac), .o_baud_update(b_upd),
    .o_locked(b_locked), .o_busy(b_busy), .o_err(b_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, want);
    end
  endtask

  task automatic judge(input string who, input exp_t e, input logic upd, input logic err,
                       input logic [12:0] baud, input logic [2:0] frac, input logic locked);
    check({who, "_err"},  32'(err),  32'(e.is_err));
    check({who, "_upd"},  32'(upd),  32'(!e.is_err));
    check({who, "_baud"}, 32'(baud), 32'(e.baud));
    check({who, "_frac"}, 32'(frac), 32'(e.frac));
    if (!e.is_err) check({who, "_locked"}, 32'(locked), 32'd1);
  endtask

  always @(negedge clk) begin
    if (a_upd || a_err) begin
      if (q_a.size() == 0) begin
        check("a_spurious_pulse", {30'd0, a_upd, a_err}, 32'd0);
      end else begin
        e_a = q_a.pop_front();
        judge("a", e_a, a_upd, a_err, a_baud, a_frac, a_locked);
      end
    end
    if (b_upd || b_err) begin
      if (q_b.size() == 0) begin
        check("b_spurious_pulse", {30'd0, b_upd, b_err}, 32'd0);
      end else begin
        e_b = q_b.pop_front();
        judge("b", e_b, b_upd, b_err, b_baud, b_frac, b_locked);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input logic is_err, input logic [12:0] baud, input logic [2:0] frac);
    q_a.push_back('{is_err: is_err, baud: baud, frac: frac});
    if (!is_err) begin
      m_baud = baud;
      m_frac = frac;
    end
  endtask

  task automatic arm_a();
    a_rx    = 1'b1;
    a_start = 1'b1;
    tick(1);
    a_start = 1'b0;
    tick(c_idle + 20);
  endtask

  task automatic send_a(input logic [7:0] c, input int b);
    a_rx = 1'b0;
    tick(b);
    for (int i = 0; i < 8; i++) begin
      a_rx = c[i];
      tick(b);
    end
    a_rx = 1'b1;
    tick(b);
  endtask

  task automatic drain_a(input int budget);
    int n = budget;
    while (q_a.size() != 0 && n > 0) begin
      tick(1);
      n--;
    end
    if (q_a.size() != 0) begin
      check("a_drain_timeout", 32'(q_a.size()), 32'd0);
      q_a.delete();
    end
  endtask

  task automatic abort_a();
    a_abort = 1'b1;
    tick(1);
    a_abort = 1'b0;
    @(negedge clk);
  endtask

  // Line stuck low after the start edge; timeout with AUTO_RETRY=0 returns to IDLE.
  task automatic run_b();
    int n = 9000;
    b_start = 1'b1;
    tick(1);
    b_start = 1'b0;
    tick(c_idle + 20);
    q_b.push_back('{is_err: 1'b1, baud: 13'd77, frac: 3'd0});
    b_rx = 1'b0;
    while (q_b.size() != 0 && n > 0) begin
      tick(1);
      n--;
    end
    if (q_b.size() != 0) begin
      check("b_drain_timeout", 32'(q_b.size()), 32'd0);
      q_b.delete();
    end
    @(negedge clk);
    check("b_busy_after_timeout", 32'(b_busy), 32'd0);
    check("b_locked_after_timeout", 32'(b_locked), 32'd0);
    check("b_baud_after_timeout", 32'(b_baud), 32'd77);
    b_rx = 1'b1;
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_a_baud",   32'(a_baud),   32'd0);
    check("rst_a_frac",   32'(a_frac),   32'd0);
    check("rst_a_locked", 32'(a_locked), 32'd0);
    check("rst_a_busy",   32'(a_busy),   32'd0);
    check("rst_a_upd",    32'(a_upd),    32'd0);
    check("rst_a_err",    32'(a_err),    32'd0);
    check("rst_b_baud",   32'(b_baud),   32'd77);

    fork
      run_b();
      begin
        // 115200 baud at 50 MHz
        arm_a();
        expect_a(1'b0, 13'd26, 3'd1);
        send_a(c_sync_char, 434);
        drain_a(2000);
        @(negedge clk);
        check("t1_upd_single_pulse", 32'(a_upd),    32'd0);
        check("t1_locked",           32'(a_locked), 32'd1);
        check("t1_busy",             32'(a_busy),   32'd0);
      end
    join

    // 9600 baud at 50 MHz
    arm_a();
    expect_a(1'b0, 13'd324, 3'd4);
    send_a(c_sync_char, 5208);
    drain_a(2000);

    // 0x41 gives an unequal second interval; a trailing char supplies the remaining edges
    arm_a();
    expect_a(1'b1, m_baud, m_frac);
    send_a(8'h41, 434);
    send_a(c_sync_char, 434);
    drain_a(2000);
    @(negedge clk);
    check("t3_busy_retry", 32'(a_busy), 32'd1);
    tick(300);
    abort_a();
    check("t3_busy_after_abort", 32'(a_busy),   32'd0);
    check("t3_baud_kept",        32'(a_baud),   32'd324);

    // Too fast (T=80), then auto-retry accepts a good sync char
    arm_a();
    expect_a(1'b1, m_baud, m_frac);
    send_a(c_sync_char, 10);
    drain_a(500);
    tick(300);
    expect_a(1'b0, 13'd26, 3'd1);
    send_a(c_sync_char, 434);
    drain_a(2000);
    @(negedge clk);
    check("t4_baud_final", 32'(a_baud), 32'd26);

    // Abort during MEASURE
    arm_a();
    a_rx = 1'b0; tick(434);
    a_rx = 1'b1; tick(434);
    a_rx = 1'b0; tick(200);
    abort_a();
    check("t6_abort_busy",   32'(a_busy),   32'd0);
    check("t6_abort_baud",   32'(a_baud),   32'd26);
    check("t6_abort_frac",   32'(a_frac),   32'd1);
    check("t6_abort_locked", 32'(a_locked), 32'd1);
    a_rx = 1'b1;
    tick(1000);

    // Reset while waiting for the stop-bit rise
    arm_a();
    a_rx = 1'b0;
    tick(434);
    for (int i = 0; i < 7; i++) begin
      a_rx = c_sync_char[i];
      tick(434);
    end
    a_rx = 1'b0;
    tick(217);
    reset = 1'b1;
    a_rx  = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check("t6_rst_baud",   32'(a_baud),   32'd0);
    check("t6_rst_frac",   32'(a_frac),   32'd0);
    check("t6_rst_locked", 32'(a_locked), 32'd0);
    check("t6_rst_busy",   32'(a_busy),   32'd0);
    check("t6_rst_upd",    32'(a_upd),    32'd0);
    check("t6_rst_err",    32'(a_err),    32'd0);
    tick(50);

    check("a_queue_left", 32'(q_a.size()), 32'd0);
    check("b_queue_left", 32'(q_b.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
